// File: rtl/bus_timer.sv
// Memory-mapped prescaled timer: compare/auto-reload counter, sticky match flag and irq.
// Writes land on the clock edge; reads are combinational for the single-cycle core.
module bus_timer #(
   parameter int unsigned CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busSel,
   input  logic        busWe,
   input  logic [31:0] busAddr,
   input  logic [31:0] busWData,
   output logic [31:0] busRData,
   output logic        irq
);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_PSC    = 3'd1;
   localparam logic [2:0] OFF_ARR    = 3'd2;
   localparam logic [2:0] OFF_CNT    = 3'd3;
   localparam logic [2:0] OFF_STATUS = 3'd4;

   logic             en_q, auto_q, ie_q, match_q;
   logic [CNT_W-1:0] psc_q, arr_q, cnt_q, psc_cnt_q;

   logic             en_d, auto_d, ie_d, match_d;
   logic [CNT_W-1:0] psc_d, arr_d, cnt_d, psc_cnt_d;

   logic             wr;
   logic             tick;
   logic             match_set;
   logic [2:0]       idx;
   logic [CNT_W-1:0] wval;
   logic [31:0]      rdata;
   logic             unused_bits;

   assign idx         = busAddr[4:2];
   assign wr          = busSel & busWe;
   assign wval        = busWData[CNT_W-1:0];
   assign tick        = en_q && (psc_cnt_q == psc_q);
   assign unused_bits = ^{busAddr[31:5], busAddr[1:0], busWData};

   // Next-state: tick update first, bus writes override it, match set beats W1C.
   always_comb begin
      en_d      = en_q;
      auto_d    = auto_q;
      ie_d      = ie_q;
      match_d   = match_q;
      psc_d     = psc_q;
      arr_d     = arr_q;
      cnt_d     = cnt_q;
      psc_cnt_d = psc_cnt_q;
      match_set = 1'b0;

      if (en_q) begin
         psc_cnt_d = tick ? '0 : psc_cnt_q + CNT_W'(1);
      end

      if (tick) begin
         if (cnt_q == arr_q) begin
            match_set = 1'b1;
            if (auto_q) begin
               cnt_d = '0;
            end else begin
               en_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (wr) begin
         case (idx)
            OFF_CTRL: begin
               en_d   = busWData[0];
               auto_d = busWData[2];
               ie_d   = busWData[3];
               if (busWData[1]) begin
                  cnt_d     = '0;
                  psc_cnt_d = '0;
               end
            end
            OFF_PSC: psc_d = wval;
            OFF_ARR: arr_d = wval;
            OFF_CNT: begin
               cnt_d     = wval;
               psc_cnt_d = '0;
            end
            OFF_STATUS: begin
               if (busWData[0]) begin
                  match_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      if (match_set) begin
         match_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q      <= 1'b0;
         auto_q    <= 1'b0;
         ie_q      <= 1'b0;
         match_q   <= 1'b0;
         psc_q     <= '0;
         arr_q     <= '0;
         cnt_q     <= '0;
         psc_cnt_q <= '0;
         irq       <= 1'b0;
      end else begin
         en_q      <= en_d;
         auto_q    <= auto_d;
         ie_q      <= ie_d;
         match_q   <= match_d;
         psc_q     <= psc_d;
         arr_q     <= arr_d;
         cnt_q     <= cnt_d;
         psc_cnt_q <= psc_cnt_d;
         irq       <= match_d & ie_d;
      end
   end

   // Read mux; CLR is write-only so CTRL bit1 always reads 0.
   always_comb begin
      rdata = 32'd0;
      case (idx)
         OFF_CTRL:   rdata = {28'd0, ie_q, auto_q, 1'b0, en_q};
         OFF_PSC:    rdata = 32'(psc_q);
         OFF_ARR:    rdata = 32'(arr_q);
         OFF_CNT:    rdata = 32'(cnt_q);
         OFF_STATUS: rdata = {31'd0, match_q};
         default:    rdata = 32'd0;
      endcase
   end

   assign busRData = busSel ? rdata : 32'd0;

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: reads push expected data, a negedge monitor pops and compares.
module tb_bus_timer;

   localparam int unsigned CNT_W = 8;
   localparam longint      MOD   = longint'(1) << CNT_W;

   logic        clk = 1'b0;
   logic        reset;
   logic        busSel, busWe;
   logic [31:0] busAddr, busWData, busRData;
   logic        irq;

   bus_timer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .busSel(busSel), .busWe(busWe),
      .busAddr(busAddr), .busWData(busWData), .busRData(busRData), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        irq;
      string       name;
   } exp_t;

   exp_t sbq[$];
   logic rd_active = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Reference model: register-level view of the timer.
   bit     m_en, m_auto, m_ie, m_match;
   longint m_psc, m_arr, m_cnt, m_pcnt;

   function automatic logic [31:0] m_read(input logic sel, input logic [31:0] addr);
      if (!sel) return 32'd0;
      case (addr[4:2])
         3'd0: return {28'd0, m_ie, m_auto, 1'b0, m_en};
         3'd1: return 32'(m_psc);
         3'd2: return 32'(m_arr);
         3'd3: return 32'(m_cnt);
         3'd4: return {31'd0, m_match};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_irq();
      return m_match & m_ie;
   endfunction

   task automatic model_edge();
      bit tick, set_m;
      bit n_en, n_auto, n_ie, n_match;
      longint n_psc, n_arr, n_cnt, n_pcnt, w;
      if (reset) begin
         m_en = 0; m_auto = 0; m_ie = 0; m_match = 0;
         m_psc = 0; m_arr = 0; m_cnt = 0; m_pcnt = 0;
         return;
      end
      n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_match = m_match;
      n_psc = m_psc; n_arr = m_arr; n_cnt = m_cnt; n_pcnt = m_pcnt;
      w = longint'(busWData) % MOD;
      tick = m_en && (m_pcnt == m_psc);
      set_m = 0;
      if (m_en) n_pcnt = tick ? 0 : (m_pcnt + 1) % MOD;
      if (tick) begin
         if (m_cnt == m_arr) begin
            set_m = 1;
            if (m_auto) n_cnt = 0;
            else n_en = 0;
         end else begin
            n_cnt = (m_cnt + 1) % MOD;
         end
      end
      if (busSel && busWe) begin
         case (busAddr[4:2])
            3'd0: begin
               n_en = busWData[0]; n_auto = busWData[2]; n_ie = busWData[3];
               if (busWData[1]) begin n_cnt = 0; n_pcnt = 0; end
            end
            3'd1: n_psc = w;
            3'd2: n_arr = w;
            3'd3: begin n_cnt = w; n_pcnt = 0; end
            3'd4: if (busWData[0]) n_match = 0;
            default: ;
         endcase
      end
      if (set_m) n_match = 1;
      m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_match = n_match;
      m_psc = n_psc; m_arr = n_arr; m_cnt = n_cnt; m_pcnt = n_pcnt;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic sel, input logic we, input logic [31:0] addr, input logic [31:0] data);
      busSel = sel; busWe = we; busAddr = addr; busWData = data;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      drive(1'b1, 1'b1, addr, data);
      step();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      step();
   endtask

   task automatic rd_exp(input logic sel, input logic [31:0] addr, input logic [31:0] exp, input string name);
      exp_t e;
      drive(sel, 1'b0, addr, 32'd0);
      e.rdata = exp; e.irq = m_irq(); e.name = name;
      sbq.push_back(e);
      rd_active = 1'b1;
      step();
      rd_active = 1'b0;
   endtask

   task automatic rd_model(input logic sel, input logic [31:0] addr, input string name);
      rd_exp(sel, addr, m_read(sel, addr), name);
   endtask

   // Monitor: compares whenever a read is presented on the bus.
   always @(negedge clk) begin
      exp_t e;
      if (rd_active) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: read with no expected entry, rdata=%h", busRData);
         end else begin
            e = sbq.pop_front();
            if (busRData !== e.rdata || irq !== e.irq) begin
               failures++;
               $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                        e.name, busRData, irq, e.rdata, e.irq);
            end
         end
      end
   end

   initial begin
      logic [31:0] v;
      logic [31:0] a;
      int          n;
      int          r;
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      step(); step();
      reset = 1'b0;

      // Reset state
      rd_exp(1, 32'h00, 0, "reset_ctrl");
      rd_exp(1, 32'h04, 0, "reset_psc");
      rd_exp(1, 32'h08, 0, "reset_arr");
      rd_exp(1, 32'h0C, 0, "reset_cnt");
      rd_exp(1, 32'h10, 0, "reset_status");

      // Auto-reload with irq
      wr(32'h04, 0);
      wr(32'h08, 4);
      wr(32'h00, 32'hD);
      rd_exp(1, 32'h0C, 0, "auto_cnt0");
      rd_exp(1, 32'h0C, 1, "auto_cnt1");
      rd_exp(1, 32'h0C, 2, "auto_cnt2");
      rd_exp(1, 32'h0C, 3, "auto_cnt3");
      rd_exp(1, 32'h0C, 4, "auto_cnt4");
      rd_exp(1, 32'h0C, 0, "auto_cnt_wrap");
      rd_exp(1, 32'h0C, 1, "auto_cnt_again");
      rd_exp(1, 32'h11, 1, "auto_match");

      // W1C on the match edge: set wins
      wr(32'h10, 1);
      rd_exp(1, 32'h10, 0, "w1c_clears");
      n = 0;
      while (!(m_cnt == m_arr && m_pcnt == m_psc) && n < 50) begin idle(); n++; end
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL race_wait: model never reached match edge, cnt=%0d", m_cnt);
      end
      wr(32'h10, 1);
      rd_exp(1, 32'h10, 1, "w1c_race_match");

      // One-shot with prescaler
      wr(32'h00, 32'h2);
      wr(32'h10, 1);
      wr(32'h04, 2);
      wr(32'h08, 3);
      wr(32'h00, 32'h1);
      for (int k = 0; k < 14; k++)
         rd_exp(1, 32'h0C, (k < 3) ? 0 : (k < 6) ? 1 : (k < 9) ? 2 : 3, "oneshot_cnt");
      rd_exp(1, 32'h10, 1, "oneshot_match");
      rd_exp(1, 32'h00, 0, "oneshot_en_cleared");

      // CNT write on a tick edge
      wr(32'h04, 0);
      wr(32'h08, 200);
      wr(32'h00, 32'h1);
      idle(); idle();
      wr(32'h0C, 32'h10);
      rd_exp(1, 32'h0C, 32'h10, "cnt_write_race");
      rd_exp(1, 32'h0C, 32'h11, "cnt_after_write");

      // CLR mid-count, then disable
      wr(32'h00, 32'h3);
      rd_exp(1, 32'h0C, 0, "clr_cnt");
      rd_exp(1, 32'h00, 1, "clr_reads_zero");
      wr(32'h00, 32'h0);
      v = 32'(m_cnt);
      for (int k = 0; k < 20; k++) rd_exp(1, 32'h0C, v, "disabled_frozen");

      // Decode
      drive(1'b0, 1'b1, 32'h08, 32'd5);
      step();
      rd_exp(0, 32'h08, 0, "unselected_read");
      rd_exp(1, 32'h08, 200, "unselected_write_ignored");
      rd_exp(1, 32'h18, 0, "unmapped_read");
      wr(32'h18, 32'hFFFF_FFFF);
      for (int k = 0; k < 5; k++) rd_model(1, 32'(k * 4), "unmapped_write_ignored");
      rd_exp(1, 32'h04, 0, "unmapped_psc_unchanged");

      // Randomized traffic against the model
      for (int it = 0; it < 1500; it++) begin
         r = $urandom_range(0, 99);
         a = $urandom();
         if (r < 2) begin
            reset = 1'b1;
            idle();
            reset = 1'b0;
         end else if (r < 50) begin
            a[4:2] = 3'($urandom_range(0, 7));
            rd_model(($urandom_range(0, 9) != 0), a, "rand_read");
         end else if (r < 92) begin
            a[4:2] = 3'($urandom_range(0, 5));
            case (a[4:2])
               3'd0: v = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 15))
                                                     : 32'($urandom_range(0, 15)) & ~32'h2 | 32'h1;
               3'd1: v = 32'($urandom_range(0, 3));
               3'd2: v = 32'($urandom_range(0, 12));
               3'd3: v = ($urandom_range(0, 4) == 0) ? $urandom() : 32'($urandom_range(0, 12));
               default: v = $urandom();
            endcase
            drive(($urandom_range(0, 9) != 0), 1'b1, a, v);
            step();
         end else begin
            idle();
         end
      end

      idle();
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
